// File: rtl/sap1_pkg.sv
// ---------------------------------------------------------------------------
// sap1_pkg
// Shared definitions for the SAP-1 program loader.
//   DEFAULT_ADDR_W : default program-memory address width (16 locations)
//   DEFAULT_DATA_W : default program-memory byte width
//   prog_state_t   : state encoding of the ram_programmer loader FSM
// ---------------------------------------------------------------------------
package sap1_pkg;

   localparam int DEFAULT_ADDR_W = 4;
   localparam int DEFAULT_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN    = 3'd1,
      ST_DATA   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_FINISH = 3'd4
   } prog_state_t;

endpackage

// File: rtl/ram_programmer.sv
// ---------------------------------------------------------------------------
// ram_programmer
// Loads a program image into the SAP-1 program memory from a valid/ready byte
// stream.
//
// A session is a length byte, that many data bytes and a checksum byte. The
// CPU is held in reset until a session finishes with a matching checksum.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high reset
//   start      : begin a new session (only looked at while idle)
//   in_valid   : in_data carries a byte
//   in_data    : incoming byte stream
//   in_ready   : a byte can be accepted this cycle
//   mem_we     : program-memory write strobe (one cycle per byte)
//   mem_addr   : program-memory write address
//   mem_wdata  : program-memory write data
//   cpu_reset  : holds the CPU in reset while memory is not valid
//   busy       : loader is in a session
//   done       : one-cycle pulse on a successful session
//   error      : sticky checksum-failure flag
// ---------------------------------------------------------------------------
module ram_programmer
   import sap1_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   prog_state_t state;
   prog_state_t state_next;

   logic              accept;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] checksum;

   // Handshake and status outputs decode straight from the state register so
   // they never glitch relative to it.
   always_comb begin
      in_ready = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHECK);
      busy     = (state != ST_IDLE);
      done     = (state == ST_FINISH);
      accept   = in_valid && in_ready;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. DATA ends on the byte written to last_addr, which
   // covers every count from 1 to 2**ADDR_W with a plain ADDR_W-bit compare.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_LEN;
            end
         end
         ST_LEN: begin
            if (accept) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (accept && (wr_addr == last_addr)) begin
               state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (accept) begin
               state_next = (in_data == checksum) ? ST_FINISH : ST_IDLE;
            end
         end
         ST_FINISH: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: address counter, inline checksum accumulator, registered
   // memory write port and the cpu_reset / error flags.
   // The last address is stored as (count - 1), so a count of 0 becomes
   // all-ones and the session writes the whole memory.
   // cpu_reset and error are cleared on the edge that enters FINISH, so both
   // already read low during the done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_addr   <= '0;
         last_addr <= '0;
         checksum  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_reset <= 1'b1;
         error     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cpu_reset <= 1'b1;
                  wr_addr   <= '0;
                  checksum  <= '0;
               end
            end
            ST_LEN: begin
               if (accept) begin
                  last_addr <= in_data[ADDR_W-1:0] - ADDR_W'(1);
                  wr_addr   <= '0;
                  checksum  <= '0;
               end
            end
            ST_DATA: begin
               if (accept) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= wr_addr;
                  mem_wdata <= in_data;
                  wr_addr   <= wr_addr + ADDR_W'(1);
                  checksum  <= checksum + in_data;
               end
            end
            ST_CHECK: begin
               if (accept) begin
                  if (in_data == checksum) begin
                     cpu_reset <= 1'b0;
                     error     <= 1'b0;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_programmer.sv
// ---------------------------------------------------------------------------
// tb_ram_programmer
// Directed self-checking bench for ram_programmer. Inputs change on the
// falling edge, outputs are observed on the falling edge, and a monitor logs
// every memory write and every done pulse.
// ---------------------------------------------------------------------------
module tb_ram_programmer;

   logic       clk;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_reset;
   logic       busy;
   logic       done;
   logic       error;

   int num_checks = 0;
   int num_fails  = 0;

   logic [3:0] wr_addr_q[$];
   logic [7:0] wr_data_q[$];
   int         done_count;
   logic       done_cpu_reset;
   logic       done_error;

   ram_programmer #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log writes and done pulses as seen between rising edges.
   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
      if (done) begin
         done_count++;
         done_cpu_reset = cpu_reset;
         done_error     = error;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Present one byte and hold it until the handshake completes.
   task automatic applyStimulus(input logic [7:0] value);
      bit taken;
      taken    = 1'b0;
      in_valid = 1'b1;
      in_data  = value;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin
            taken = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      if (!taken) begin
         checkOutput("handshake_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      done_count     = 0;
      done_cpu_reset = 1'bx;
      done_error     = 1'bx;
   endtask

   task automatic start_session();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
      end
   endtask

   task automatic check_writes(input string tag, input logic [3:0] addrs[],
                               input logic [7:0] datas[]);
      checkOutput({tag, "_write_count"}, wr_addr_q.size(), addrs.size());
      for (int i = 0; i < addrs.size() && i < wr_addr_q.size(); i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], addrs[i]);
         checkOutput($sformatf("%s_data%0d", tag, i), wr_data_q[i], datas[i]);
      end
   endtask

   initial begin
      logic [3:0] a[];
      logic [7:0] d[];

      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      clear_logs();

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready",  in_ready,  0);
      checkOutput("rst_mem_we",    mem_we,    0);
      checkOutput("rst_mem_addr",  mem_addr,  0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      checkOutput("rst_busy",      busy,      0);
      checkOutput("rst_done",      done,      0);
      checkOutput("rst_error",     error,     0);
      checkOutput("rst_cpu_reset", cpu_reset, 1);
      reset = 1'b0;
      @(negedge clk);

      // Session 1: three bytes, good checksum.
      clear_logs();
      start_session();
      checkOutput("s1_busy",     busy,     1);
      checkOutput("s1_in_ready", in_ready, 1);
      applyStimulus(8'h03);
      applyStimulus(8'h0E);
      applyStimulus(8'h1F);
      applyStimulus(8'h2D);
      applyStimulus(8'h5A);
      idle_cycles(4);
      a = '{4'd0, 4'd1, 4'd2};
      d = '{8'h0E, 8'h1F, 8'h2D};
      check_writes("s1", a, d);
      checkOutput("s1_done_count",   done_count,     1);
      checkOutput("s1_done_cpu_rst", done_cpu_reset, 0);
      checkOutput("s1_done_error",   done_error,     0);
      checkOutput("s1_cpu_reset",    cpu_reset,      0);
      checkOutput("s1_error",        error,          0);
      checkOutput("s1_busy_end",     busy,           0);

      // Session 2: bad checksum.
      clear_logs();
      start_session();
      checkOutput("s2_cpu_reset_start", cpu_reset, 1);
      applyStimulus(8'h02);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h00);
      idle_cycles(4);
      a = '{4'd0, 4'd1};
      d = '{8'h11, 8'h22};
      check_writes("s2", a, d);
      checkOutput("s2_done_count", done_count, 0);
      checkOutput("s2_error",      error,      1);
      checkOutput("s2_cpu_reset",  cpu_reset,  1);
      checkOutput("s2_busy_end",   busy,       0);

      // Session 3: count 0 means the full 16-byte memory.
      clear_logs();
      start_session();
      checkOutput("s3_error_sticky", error, 1);
      applyStimulus(8'h00);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'h01);
      end
      checkOutput("s3_in_check", in_ready, 1);
      applyStimulus(8'h10);
      idle_cycles(4);
      a = new[16];
      d = new[16];
      for (int i = 0; i < 16; i++) begin
         a[i] = 4'(i);
         d[i] = 8'h01;
      end
      check_writes("s3", a, d);
      checkOutput("s3_done_count",   done_count,     1);
      checkOutput("s3_done_cpu_rst", done_cpu_reset, 0);
      checkOutput("s3_done_error",   done_error,     0);
      checkOutput("s3_error",        error,          0);
      checkOutput("s3_last_addr",    mem_addr,       4'hF);

      // Session 4: gaps in in_valid with garbage data between bytes.
      // Checksum A1+B2+C3+D4 = 0x2EA -> EA.
      clear_logs();
      start_session();
      applyStimulus(8'h04);
      d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            in_data = 8'($urandom_range(0, 255));
            @(negedge clk);
         end
         in_data = 8'h5E;
         @(negedge clk);
         applyStimulus(d[i]);
      end
      in_valid = 1'b0;
      in_data  = 8'h99;
      @(negedge clk);
      applyStimulus(8'hEA);
      idle_cycles(4);
      a = '{4'd0, 4'd1, 4'd2, 4'd3};
      check_writes("s4", a, d);
      checkOutput("s4_done_count", done_count, 1);
      checkOutput("s4_error",      error,      0);

      // Session 5: reset after the second data byte, then a clean session.
      clear_logs();
      start_session();
      applyStimulus(8'h05);
      applyStimulus(8'h10);
      applyStimulus(8'h20);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      a = '{4'd0, 4'd1};
      d = '{8'h10, 8'h20};
      check_writes("s5_abort", a, d);
      checkOutput("s5_busy",      busy,      0);
      checkOutput("s5_in_ready",  in_ready,  0);
      checkOutput("s5_cpu_reset", cpu_reset, 1);
      checkOutput("s5_done_count", done_count, 0);
      clear_logs();
      start_session();
      applyStimulus(8'h01);
      applyStimulus(8'h5C);
      applyStimulus(8'h5C);
      idle_cycles(4);
      a = '{4'd0};
      d = '{8'h5C};
      check_writes("s5_rerun", a, d);
      checkOutput("s5_rerun_done", done_count, 1);
      checkOutput("s5_rerun_cpu_reset", cpu_reset, 0);

      // Session 6: start pulsed mid-stream, upper count bits ignored (0x12 -> 2).
      clear_logs();
      start_session();
      applyStimulus(8'h12);
      applyStimulus(8'h33);
      start    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      applyStimulus(8'h44);
      applyStimulus(8'h77);
      idle_cycles(4);
      a = '{4'd0, 4'd1};
      d = '{8'h33, 8'h44};
      check_writes("s6", a, d);
      checkOutput("s6_done_count", done_count, 1);
      checkOutput("s6_error",      error,      0);
      checkOutput("s6_busy_end",   busy,       0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               num_checks, num_fails);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/ram_programmer.md
RAM_PROGRAMMER -- requirements
Module: ram_programmer

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the memory address width; depth is 2**ADDR_W (16).
REQ-002 Parameter DATA_W, default 8, SHALL set the data byte width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a new programming session; sampled only in IDLE.
REQ-006 in_valid  input  1  SHALL mark in_data as valid.
REQ-007 in_data  input  DATA_W  SHALL carry the incoming byte stream.
REQ-008 in_ready  output  1  SHALL indicate a byte can be accepted this cycle.
REQ-009 mem_we  output  1  SHALL be the program-memory write strobe.
REQ-010 mem_addr  output  ADDR_W  SHALL be the program-memory write address.
REQ-011 mem_wdata  output  DATA_W  SHALL be the program-memory write data.
REQ-012 cpu_reset  output  1  SHALL hold the CPU in reset while memory contents are not valid.
REQ-013 busy  output  1  SHALL be high in any state other than IDLE.
REQ-014 done  output  1  SHALL be a one-cycle pulse on a successful session.
REQ-015 error  output  1  SHALL be a sticky checksum-failure flag.

Function
REQ-016 A byte SHALL transfer on a rising edge where in_valid and in_ready are both high; in_data SHALL be ignored otherwise.
REQ-017 The FSM SHALL have states IDLE, LEN, DATA, CHECK and FINISH.
REQ-018 IDLE -> LEN SHALL occur on start=1; start SHALL be ignored outside IDLE.
REQ-019 In LEN, the first accepted byte SHALL give count N from its low ADDR_W bits; N=0 SHALL mean 2**ADDR_W; upper bits are ignored. The FSM SHALL then go to DATA.
REQ-020 In DATA, the k-th accepted byte (k=0..N-1) SHALL be written to address k. After byte N-1 is accepted the FSM SHALL go to CHECK.
REQ-021 Each write SHALL be registered: mem_we high for exactly one cycle, on the cycle after acceptance, with mem_addr and mem_wdata valid in that same cycle.
REQ-022 Back-to-back acceptances SHALL produce back-to-back write cycles with no bubble.
REQ-023 The running checksum SHALL be the DATA_W-bit modulo-2**DATA_W sum of all data bytes.
REQ-024 In CHECK, the accepted byte SHALL be compared with the checksum. On a match the FSM SHALL go to FINISH. On a mismatch it SHALL set error=1 and return to IDLE with cpu_reset still high.
REQ-025 FINISH SHALL last one cycle, in which done=1, error is cleared and cpu_reset is cleared; the FSM SHALL then return to IDLE.
REQ-026 in_ready SHALL be high in LEN, DATA and CHECK, and low in IDLE and FINISH.
REQ-027 cpu_reset SHALL go high on the cycle after start is accepted and remain high until FINISH.
REQ-028 error SHALL clear only in FINISH or on reset.
REQ-029 The address counter SHALL be ADDR_W bits; with N=16 it SHALL wrap to 0 only after the last write, and no extra write SHALL occur.

Reset
REQ-030 On reset the FSM SHALL enter IDLE, with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0 and cpu_reset=1.
REQ-031 A reset mid-session SHALL abort with no further writes; bytes already written SHALL remain in memory, and cpu_reset SHALL stay 1.

Structure
REQ-032 The FSM state encoding and the defaults ADDR_W=4 and DATA_W=8 SHALL live in a shared sap1 package.
REQ-033 The block SHALL be one module with no sub-modules; the checksum accumulator SHALL be inline.

Verification
REQ-034 Reset, start, then stream 03,0E,1F,2D,5A (0E+1F+2D=5A) -> writes 0:0E, 1:1F, 2:2D; done pulses once; cpu_reset falls in FINISH; error=0.
REQ-035 Session 02,11,22,00 -> both writes occur; error=1; done never pulses; cpu_reset stays 1.
REQ-036 Count 00 then 16 bytes of 01 and checksum 10 -> addresses 0..15 written; exactly 16 mem_we pulses; success.
REQ-037 in_valid toggled randomly during DATA -> one write per handshake only; in_data changes while in_valid=0 are never written.
REQ-038 Reset asserted after the second data byte -> no further mem_we; state is IDLE with cpu_reset=1; a following start then runs a full session normally.
REQ-039 start pulsed during DATA -> ignored; session completes unchanged.
